regsrc_recovery_ctrl: RTL and testbench

//  Sequencer for the register-source (rename) table. After reset it sweeps every

---
 rtl/regsrc_recovery_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_regsrc_recovery_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regsrc_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// regsrc_recovery_ctrl
//
// Sequencer for the register-source (rename) table.
//   * After reset it sweeps every architectural entry to "not renamed"
//     (all-ones), LANES entries per cycle.
//   * After a branch miss it waits SETTLE cycles, then scans the issue queue
//     LANES entries per cycle. For each entry that is the latest writer of its
//     target, it emits a table write restoring {1'b0, rob_id}.
//   * busy is high for the whole sequence so rename and queueing can stall.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active low
//   branchmiss  branch-miss level; a rising edge starts a recovery
//   iq_latest   bit n: IQ entry n is the latest writer of its target
//   iq_tgt      target register per entry, entry n at [n*TAGW +: TAGW]
//   iq_rid      ROB id per entry, entry n at [n*RIDW +: RIDW]
//   wr_en       per-lane table write enable
//   wr_tgt      per-lane table index, lane j at [j*TAGW +: TAGW]
//   wr_val      per-lane table data, lane j at [j*(RIDW+1) +: RIDW+1]
//   busy        sequence in progress
//   done        one-cycle pulse when a sequence completes
//
// All outputs are registered. When several lanes target the same register in
// one cycle, the table applies lanes in ascending order, so the highest IQ
// index wins; no de-duplication is done here.
// -----------------------------------------------------------------------------
module regsrc_recovery_ctrl #(
  parameter int AREGS      = 128,
  parameter int IQ_ENTRIES = 32,
  parameter int TAGW       = 7,
  parameter int RIDW       = 5,
  parameter int LANES      = 4,
  parameter int SETTLE     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         branchmiss,
  input  logic [IQ_ENTRIES-1:0]        iq_latest,
  input  logic [IQ_ENTRIES*TAGW-1:0]   iq_tgt,
  input  logic [IQ_ENTRIES*RIDW-1:0]   iq_rid,
  output logic [LANES-1:0]             wr_en,
  output logic [LANES*TAGW-1:0]        wr_tgt,
  output logic [LANES*(RIDW+1)-1:0]    wr_val,
  output logic                         busy,
  output logic                         done
);

  localparam int VALW        = RIDW + 1;
  localparam int INIT_GROUPS = AREGS / LANES;
  localparam int SCAN_GROUPS = IQ_ENTRIES / LANES;
  localparam int MAX_GROUPS  = (INIT_GROUPS > SCAN_GROUPS) ? INIT_GROUPS : SCAN_GROUPS;
  // The index counts one past the last group: that extra step is the done cycle.
  localparam int IDXW        = $clog2(MAX_GROUPS + 1);
  localparam int SGW         = (SCAN_GROUPS > 1) ? $clog2(SCAN_GROUPS) : 1;
  // The settle counter holds the remaining SETTLE-state cycles (0..SETTLE-2).
  localparam int CNTW        = (SETTLE > 2) ? $clog2(SETTLE - 1) : 1;

  localparam logic [IDXW-1:0] INIT_LAST = IDXW'(INIT_GROUPS);
  localparam logic [IDXW-1:0] SCAN_LAST = IDXW'(SCAN_GROUPS);
  localparam logic [CNTW-1:0] CNT_LOAD  = CNTW'((SETTLE > 2) ? SETTLE - 2 : 0);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SCAN   = 2'd3
  } state_t;

  // The state register itself accounts for one waiting cycle, so with
  // SETTLE == 1 the SETTLE state is skipped entirely.
  localparam state_t SETTLE_ENTRY = (SETTLE > 1) ? ST_SETTLE : ST_SCAN;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   bm_prev_q, bm_prev_d;
  logic [LANES-1:0]       wr_en_q, wr_en_d;
  logic [LANES*TAGW-1:0]  wr_tgt_q, wr_tgt_d;
  logic [LANES*VALW-1:0]  wr_val_q, wr_val_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   bm_edge;
  logic [SGW-1:0]         grp_sel;
  logic [LANES-1:0]       scan_en;
  logic [LANES*TAGW-1:0]  scan_tgt;
  logic [LANES*VALW-1:0]  scan_val;
  logic [LANES*TAGW-1:0]  init_tgt;

  assign bm_edge = branchmiss & ~bm_prev_q;
  assign grp_sel = idx_q[SGW-1:0];

  // Per-lane view of the issue queue: lane gi of group gj is entry gj*LANES+gi.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SCAN_GROUPS-1:0] grp_en;
    logic [TAGW-1:0]        grp_tgt [SCAN_GROUPS];
    logic [RIDW-1:0]        grp_rid [SCAN_GROUPS];

    for (genvar gj = 0; gj < SCAN_GROUPS; gj++) begin : g_grp
      assign grp_en[gj]  = iq_latest[gj*LANES + gi];
      assign grp_tgt[gj] = iq_tgt[(gj*LANES + gi)*TAGW +: TAGW];
      assign grp_rid[gj] = iq_rid[(gj*LANES + gi)*RIDW +: RIDW];
    end

    assign scan_en[gi]                = grp_en[grp_sel];
    assign scan_tgt[gi*TAGW +: TAGW]  = grp_tgt[grp_sel];
    assign scan_val[gi*VALW +: VALW]  = {1'b0, grp_rid[grp_sel]};
    assign init_tgt[gi*TAGW +: TAGW]  = TAGW'(32'(idx_q) * LANES + gi);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    bm_prev_d = branchmiss;
    wr_en_d   = '0;
    wr_tgt_d  = wr_tgt_q;
    wr_val_d  = wr_val_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        if (idx_q == INIT_LAST) begin
          // Sweep finished. A branch miss seen during the sweep (or right now)
          // goes straight into SETTLE so busy never drops.
          done_d    = 1'b1;
          idx_d     = '0;
          pending_d = 1'b0;
          if (pending_q || bm_edge) begin
            state_d = SETTLE_ENTRY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          pending_d = pending_q | bm_edge;
          wr_en_d   = '1;
          wr_tgt_d  = init_tgt;
          wr_val_d  = '1;
          idx_d     = idx_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (bm_edge) begin
          state_d = SETTLE_ENTRY;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (bm_edge) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SCAN: begin
        if (bm_edge) begin
          // A newer miss invalidates this scan: start over, no done pulse.
          state_d = SETTLE_ENTRY;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
        end else if (idx_q == SCAN_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          wr_en_d  = scan_en;
          wr_tgt_d = scan_tgt;
          wr_val_d = scan_val;
          idx_d    = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      bm_prev_q <= 1'b0;
      wr_en_q   <= '0;
      wr_tgt_q  <= '0;
      wr_val_q  <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      bm_prev_q <= bm_prev_d;
      wr_en_q   <= wr_en_d;
      wr_tgt_q  <= wr_tgt_d;
      wr_val_q  <= wr_val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en  = wr_en_q;
  assign wr_tgt = wr_tgt_q;
  assign wr_val = wr_val_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_regsrc_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regsrc_recovery_ctrl
//
// Directed bench for regsrc_recovery_ctrl with default parameters. "Cycle c"
// is the interval after the c-th rising clock edge counted from the reference
// point of each test; outputs are sampled 1 ns after the edge. A small table
// model applies every write the DUT issues so restored values can be checked.
// -----------------------------------------------------------------------------
module tb_regsrc_recovery_ctrl;

  localparam int AREGS = 128;
  localparam int IQ    = 32;
  localparam int TAGW  = 7;
  localparam int RIDW  = 5;
  localparam int LANES = 4;
  localparam int VALW  = RIDW + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 branchmiss = 1'b0;
  logic [IQ-1:0]        iq_latest = '0;
  logic [IQ*TAGW-1:0]   iq_tgt = '0;
  logic [IQ*RIDW-1:0]   iq_rid = '0;
  logic [LANES-1:0]     wr_en;
  logic [LANES*TAGW-1:0] wr_tgt;
  logic [LANES*VALW-1:0] wr_val;
  logic                 busy;
  logic                 done;

  regsrc_recovery_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .branchmiss (branchmiss),
    .iq_latest  (iq_latest),
    .iq_tgt     (iq_tgt),
    .iq_rid     (iq_rid),
    .wr_en      (wr_en),
    .wr_tgt     (wr_tgt),
    .wr_val     (wr_val),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [VALW-1:0] tbl    [AREGS];
  logic [TAGW-1:0] tb_tgt [IQ];
  logic [RIDW-1:0] tb_rid [IQ];
  logic [IQ-1:0]   tb_lat;

  logic [LANES*TAGW-1:0] exp_tgt;
  logic [LANES*VALW-1:0] exp_val;

  typedef struct {
    logic       bm;     // branchmiss driven during the cycle before the check
    logic       busy;
    logic       done;
    logic [3:0] en;
    int         grp;    // scan group expected on wr_tgt/wr_val, -1 = hold
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_iq();
    for (int n = 0; n < IQ; n++) begin
      iq_tgt[n*TAGW +: TAGW] = tb_tgt[n];
      iq_rid[n*RIDW +: RIDW] = tb_rid[n];
    end
    iq_latest = tb_lat;
  endtask

  // Apply this cycle's writes to the table model (lanes ascending), then
  // advance one clock and settle 1 ns past the edge.
  task automatic step();
    for (int j = 0; j < LANES; j++)
      if (wr_en[j] === 1'b1) tbl[wr_tgt[j*TAGW +: TAGW]] = wr_val[j*VALW +: VALW];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    branchmiss = 1'b0;
    step();
    step();
    rst = 1'b1;
    cyc = 0;
  endtask

  // Full INIT sweep from reset release: 32 write cycles then done in cycle 33.
  task automatic check_init_sweep(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk({tag, "_en"}, wr_en, 4'hF);
      chk({tag, "_tgt"}, wr_tgt, {7'(4*(k-1)+3), 7'(4*(k-1)+2), 7'(4*(k-1)+1), 7'(4*(k-1))});
      chk({tag, "_val"}, wr_val, 24'hFFFFFF);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_done"}, done, 1'b0);
    end
    step();
    chk({tag, "_done_pulse"}, done, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_en_end"}, wr_en, 4'h0);
    $display("%s: sweep complete at cycle %0d", tag, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, done_cyc, nwr;
    logic [3:0] e_en;
    logic       e_busy, e_done;

    for (int a = 0; a < AREGS; a++) tbl[a] = '0;
    for (int n = 0; n < IQ; n++) begin
      tb_tgt[n] = 7'(n*5 + 1);
      tb_rid[n] = 5'(n);
    end
    tb_lat = '0;
    set_iq();

    // ---- 1: reset values and INIT sweep ----
    do_reset();
    chk("rst_en", wr_en, 4'h0);
    chk("rst_tgt", wr_tgt, 28'h0);
    chk("rst_val", wr_val, 24'h0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_done", done, 1'b0);
    check_init_sweep("init");
    step();
    chk("init_done_clear", done, 1'b0);
    begin
      int bad = 0;
      for (int a = 0; a < AREGS; a++) if (tbl[a] !== 6'h3F) bad++;
      chk("init_table_all_ones", bad, 0);
    end

    // ---- 2: table-driven scan, latest entries 0, 1, 31 ----
    tb_tgt[0] = 7'd3;   tb_rid[0] = 5'd0;
    tb_tgt[1] = 7'd9;   tb_rid[1] = 5'd5;
    tb_tgt[31] = 7'd127; tb_rid[31] = 5'd31;
    tb_lat = '0;
    tb_lat[0] = 1'b1; tb_lat[1] = 1'b1; tb_lat[31] = 1'b1;
    set_iq();

    vecs[0]  = '{bm: 1'b1, busy: 1'b1, done: 1'b0, en: 4'h0, grp: -1};
    vecs[1]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: -1};
    vecs[2]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h3, grp: 0};
    vecs[3]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 1};
    vecs[4]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 2};
    vecs[5]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 3};
    vecs[6]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 4};
    vecs[7]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 5};
    vecs[8]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h0, grp: 6};
    vecs[9]  = '{bm: 1'b0, busy: 1'b1, done: 1'b0, en: 4'h8, grp: 7};
    vecs[10] = '{bm: 1'b0, busy: 1'b0, done: 1'b1, en: 4'h0, grp: -1};
    vecs[11] = '{bm: 1'b0, busy: 1'b0, done: 1'b0, en: 4'h0, grp: -1};

    exp_tgt = {7'd127, 7'd126, 7'd125, 7'd124};
    exp_val = 24'hFFFFFF;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      branchmiss = vecs[i].bm;
      step();
      if (vecs[i].grp >= 0) begin
        for (int j = 0; j < LANES; j++) begin
          exp_tgt[j*TAGW +: TAGW] = tb_tgt[vecs[i].grp*LANES + j];
          exp_val[j*VALW +: VALW] = {1'b0, tb_rid[vecs[i].grp*LANES + j]};
        end
      end
      $display("vec %0d cycle %0d: en=%h busy=%b done=%b tgt=%h val=%h",
               i, cyc, wr_en, busy, done, wr_tgt, wr_val);
      chk("vec_en", wr_en, vecs[i].en);
      chk("vec_busy", busy, vecs[i].busy);
      chk("vec_done", done, vecs[i].done);
      chk("vec_tgt", wr_tgt, exp_tgt);
      chk("vec_val", wr_val, exp_val);
      if (cyc == 3) begin
        chk("c3_lane0_tgt", wr_tgt[6:0], 7'd3);
        chk("c3_lane0_val", wr_val[5:0], 6'd0);
        chk("c3_lane1_tgt", wr_tgt[13:7], 7'd9);
        chk("c3_lane1_val", wr_val[11:6], 6'd5);
      end
      if (cyc == 10) begin
        chk("c10_lane3_tgt", wr_tgt[27:21], 7'd127);
        chk("c10_lane3_val", wr_val[23:18], 6'd31);
      end
    end
    chk("tbl3", tbl[3], 6'd0);
    chk("tbl9", tbl[9], 6'd5);
    chk("tbl127", tbl[127], 6'd31);

    // ---- 3: two lanes of one group share a target ----
    tb_lat = '0;
    tb_lat[2] = 1'b1; tb_lat[3] = 1'b1;
    tb_tgt[2] = 7'd7; tb_rid[2] = 5'd2;
    tb_tgt[3] = 7'd7; tb_rid[3] = 5'd3;
    set_iq();
    cyc = 0;
    branchmiss = 1'b1;
    step();
    branchmiss = 1'b0;
    step();
    step();
    $display("dup cycle %0d: en=%h tgt=%h", cyc, wr_en, wr_tgt);
    chk("dup_en", wr_en, 4'hC);
    chk("dup_lane2_tgt", wr_tgt[20:14], 7'd7);
    chk("dup_lane3_tgt", wr_tgt[27:21], 7'd7);
    for (int k = 4; k <= 11; k++) step();
    chk("dup_done", done, 1'b1);
    step();
    chk("dup_tbl7", tbl[7], 6'd3);

    // ---- 4a: branchmiss held high for 40 cycles ----
    tb_lat[16] = 1'b1; tb_tgt[16] = 7'd20; tb_rid[16] = 5'd16;
    set_iq();
    cyc = 0; ndone = 0; done_cyc = -1; nwr = 0;
    for (int c = 1; c <= 45; c++) begin
      branchmiss = (c - 1 < 40);
      step();
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (wr_en !== 4'h0) nwr++;
    end
    $display("held-high: %0d done pulses, first at cycle %0d, %0d write cycles", ndone, done_cyc, nwr);
    chk("held_ndone", ndone, 1);
    chk("held_done_cycle", done_cyc, 11);
    chk("held_nwrites", nwr, 2);
    chk("held_busy_end", busy, 1'b0);

    // ---- 4b: second edge during the scan restarts it ----
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      branchmiss = (c - 1 == 0) || (c - 1 == 6);
      step();
      e_en   = (c == 3 || c == 9) ? 4'hC : (c == 13) ? 4'h1 : 4'h0;
      e_busy = (c <= 16);
      e_done = (c == 17);
      $display("restart cycle %0d: en=%h busy=%b done=%b", c, wr_en, busy, done);
      chk("restart_en", wr_en, e_en);
      chk("restart_busy", busy, e_busy);
      chk("restart_done", done, e_done);
    end

    // ---- 5: edge during INIT is queued behind the sweep ----
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      branchmiss = (c - 1 == 9);
      step();
      e_en   = (c <= 32) ? 4'hF : (c == 35) ? 4'hC : (c == 39) ? 4'h1 : 4'h0;
      e_busy = (c <= 42);
      e_done = (c == 33) || (c == 43);
      chk("pend_en", wr_en, e_en);
      chk("pend_busy", busy, e_busy);
      chk("pend_done", done, e_done);
    end
    $display("pending: sequence ended at cycle %0d busy=%b", cyc, busy);

    // ---- 6: asynchronous reset during scan group 4 ----
    cyc = 0;
    branchmiss = 1'b1;
    step();
    branchmiss = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    chk("arst_pre_en", wr_en, 4'h1);
    #2;
    rst = 1'b0;
    #1;
    $display("async reset mid-cycle: en=%h busy=%b done=%b", wr_en, busy, done);
    chk("arst_en", wr_en, 4'h0);
    chk("arst_busy", busy, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_tgt", wr_tgt, 28'h0);
    chk("arst_val", wr_val, 24'h0);
    step();
    rst = 1'b1;
    cyc = 0;
    check_init_sweep("reinit");
    for (int c = 34; c <= 40; c++) begin
      step();
      chk("reinit_no_stale_en", wr_en, 4'h0);
      chk("reinit_idle_busy", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
